// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Used by mem_port_arbiter and mem_arb_pick.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_DM = 1'b1;

    localparam int LAT_CNT_W = 4;
    localparam int STREAK_W  = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant decision between IF and DM; DM wins ties unless the
// fairness path (FAIR_EN) sees IF has waited through a full DM streak.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter bit FAIR_EN = 1'b0
) (
    input  logic                if_req_i,
    input  logic                dm_req_i,
    input  logic [STREAK_W-1:0] streak_i,
    input  logic [STREAK_W-1:0] max_streak_i,
    output logic                grant_o
);

    logic fair_win;

    assign fair_win = FAIR_EN && if_req_i && (streak_i == max_streak_i);

    always_comb begin
        grant_o = SEL_IF;
        if (fair_win) begin
            grant_o = SEL_IF;
        end else if (dm_req_i) begin
            grant_o = SEL_DM;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between instruction fetch and load/store.
// Define MEM_ARB_FAIR_EN to bound how long IF can be starved by DM.
//
// state  | meaning
// IDLE   | waiting for a request; grant decided and latched here
// ACCESS | memory busy for MEM_LAT cycles, mem_en on the first one
// DONE   | one-cycle ack to the granted requester, rdata valid
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int MAX_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic        mem_sel,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD   = LAT_CNT_W'(MEM_LAT - 1);
    localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(MAX_STREAK);

    state_e                 state_q, state_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   sel_q, sel_d;
    logic                   we_q, we_d;
    logic                   en_q, en_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [STREAK_W-1:0]    streak_q;
    logic                   grant;

    // Addresses are steered by the external selector driven from mem_sel.
    logic unused_addr;
    assign unused_addr = ^{if_addr, dm_addr};

`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR_EN = 1'b1;
    logic [STREAK_W-1:0] streak_d;

    always_comb begin
        streak_d = streak_q;
        if (state_q == IDLE) begin
            if (!if_req || grant == SEL_IF) begin
                streak_d = '0;
            end else if (streak_q != '1) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    localparam bit FAIR_EN = 1'b0;
    assign streak_q = '0;
`endif

    mem_arb_pick #(
        .FAIR_EN (FAIR_EN)
    ) u_pick (
        .if_req_i     (if_req),
        .dm_req_i     (dm_req),
        .streak_i     (streak_q),
        .max_streak_i (STREAK_MAX),
        .grant_o      (grant)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        we_d    = we_q;
        en_d    = 1'b0;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    state_d = ACCESS;
                    cnt_d   = LAT_LOAD;
                    en_d    = 1'b1;
                    sel_d   = grant;
                    we_d    = (grant == SEL_DM) && dm_we;
                    if (grant == SEL_DM) begin
                        wdata_d = dm_wdata;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            en_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            en_q    <= en_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign if_ack    = (state_q == DONE) && (sel_q == SEL_IF);
    assign dm_ack    = (state_q == DONE) && (sel_q == SEL_DM);
    assign rdata     = rdata_q;
    assign mem_en    = en_q;
    assign mem_we    = we_q;
    assign mem_sel   = sel_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with MEM_LAT=2.
// Fairness expectations follow MEM_ARB_FAIR_EN when defined.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] rdata;
    logic        mem_en;
    logic        mem_we;
    logic        mem_sel;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_cmp;
    int n_err;

    mem_port_arbiter #(
        .MEM_LAT    (2),
        .MAX_STREAK (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin : stim
        logic        g [10];
        int          k;
        int          first_en;
        int          second_en;
        int          found;
        logic        exp_sel;

        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        tick();
        tick();

        // reset state
        chk("rst_if_ack", {31'd0, if_ack}, 32'd0);
        chk("rst_dm_ack", {31'd0, dm_ack}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_sel", {31'd0, mem_sel}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        tick();

        // lone IF read
        if_req    = 1'b1;
        if_addr   = 32'h0040_0000;
        mem_rdata = 32'h2408_0005;
        tick();
        chk("if_rd_en_n1", {31'd0, mem_en}, 32'd1);
        chk("if_rd_sel_n1", {31'd0, mem_sel}, 32'd0);
        chk("if_rd_we_n1", {31'd0, mem_we}, 32'd0);
        tick();
        chk("if_rd_en_n2", {31'd0, mem_en}, 32'd0);
        chk("if_rd_ack_n2", {31'd0, if_ack}, 32'd0);
        tick();
        chk("if_rd_ack_n3", {31'd0, if_ack}, 32'd1);
        chk("if_rd_dmack_n3", {31'd0, dm_ack}, 32'd0);
        chk("if_rd_rdata_n3", rdata, 32'h2408_0005);
        if_req = 1'b0;
        tick();
        chk("if_rd_ack_n4", {31'd0, if_ack}, 32'd0);

        // DM store
        mem_rdata = 32'h1111_1111;
        dm_req    = 1'b1;
        dm_we     = 1'b1;
        dm_addr   = 32'h1001_0004;
        dm_wdata  = 32'hDEAD_BEEF;
        tick();
        chk("st_en_n1", {31'd0, mem_en}, 32'd1);
        chk("st_sel_n1", {31'd0, mem_sel}, 32'd1);
        chk("st_we_n1", {31'd0, mem_we}, 32'd1);
        chk("st_wdata_n1", mem_wdata, 32'hDEAD_BEEF);
        tick();
        chk("st_en_n2", {31'd0, mem_en}, 32'd0);
        chk("st_we_n2", {31'd0, mem_we}, 32'd1);
        tick();
        chk("st_ack_n3", {31'd0, dm_ack}, 32'd1);
        chk("st_ifack_n3", {31'd0, if_ack}, 32'd0);
        chk("st_rdata_n3", rdata, 32'h2408_0005);
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick();
        chk("st_ack_n4", {31'd0, dm_ack}, 32'd0);

        // simultaneous requests: DM first, then IF
        if_req    = 1'b1;
        dm_req    = 1'b1;
        mem_rdata = 32'hAAAA_0001;
        tick();
        chk("both_sel_dm", {31'd0, mem_sel}, 32'd1);
        chk("both_en_dm", {31'd0, mem_en}, 32'd1);
        chk("both_we_dm", {31'd0, mem_we}, 32'd0);
        tick();
        tick();
        chk("both_dm_ack", {31'd0, dm_ack}, 32'd1);
        chk("both_dm_rdata", rdata, 32'hAAAA_0001);
        dm_req    = 1'b0;
        mem_rdata = 32'hBBBB_0002;
        tick();
        chk("both_idle_noack", {31'd0, dm_ack | if_ack}, 32'd0);
        tick();
        chk("both_sel_if", {31'd0, mem_sel}, 32'd0);
        chk("both_en_if", {31'd0, mem_en}, 32'd1);
        tick();
        tick();
        chk("both_if_ack", {31'd0, if_ack}, 32'd1);
        chk("both_if_rdata", rdata, 32'hBBBB_0002);
        if_req = 1'b0;
        tick();
        tick();

        // grant sequence with both requests held continuously
        if_req = 1'b1;
        dm_req = 1'b1;
        k      = 0;
        for (int c = 0; c < 100 && k < 10; c++) begin
            tick();
            if (mem_en) begin
                g[k] = mem_sel;
                k++;
            end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        chk("streak_grant_count", k, 10);
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_FAIR_EN
            exp_sel = (i % 5 == 4) ? 1'b0 : 1'b1;
`else
            exp_sel = 1'b1;
`endif
            chk($sformatf("streak_grant_%0d", i), {31'd0, g[i]}, {31'd0, exp_sel});
        end
        repeat (5) tick();

        // back-to-back IF reads with req held across ack
        if_req    = 1'b1;
        found     = 0;
        first_en  = -1;
        second_en = -1;
        for (int c = 0; c < 30 && found < 2; c++) begin
            tick();
            if (mem_en) begin
                if (found == 0) first_en = c;
                else second_en = c;
                found++;
            end
        end
        if_req = 1'b0;
        chk("b2b_found", found, 2);
        chk("b2b_spacing", second_en - first_en, 4);
        repeat (5) tick();

        // reset in the second ACCESS cycle
        dm_req = 1'b1;
        dm_we  = 1'b1;
        tick();
        chk("rstmid_en", {31'd0, mem_en}, 32'd1);
        chk("rstmid_sel", {31'd0, mem_sel}, 32'd1);
        tick();
        rst    = 1'b1;
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick();
        chk("rstmid_if_ack", {31'd0, if_ack}, 32'd0);
        chk("rstmid_dm_ack", {31'd0, dm_ack}, 32'd0);
        chk("rstmid_rdata", rdata, 32'd0);
        chk("rstmid_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rstmid_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rstmid_mem_sel", {31'd0, mem_sel}, 32'd0);
        chk("rstmid_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("rstmid_noack_%0d", c), {31'd0, dm_ack | if_ack}, 32'd0);
        end
        if_req = 1'b1;
        tick();
        chk("post_rst_en", {31'd0, mem_en}, 32'd1);
        chk("post_rst_sel", {31'd0, mem_sel}, 32'd0);
        if_req = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
